alu_op_sequencer: RTL and testbench

- Sequential initiator for the combinational KGP ALU (6-bit a/b, 4-bit op c, 8-bit result d).
- Accepts operation requests on a valid/ready port and drives operands/opcode to the ALU.
- Holds operands stable for a programmable settle window, then captures d into a small result FIFO.
- Returns results in request order on a valid/ready response port, so the ALU can sit inside clocked datapaths.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_fifo.sv | 51 +++++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } seq_state_e;

    localparam int DEF_A_W   = 6;
    localparam int DEF_B_W   = 6;
    localparam int DEF_OP_W  = 4;
    localparam int DEF_RES_W = 8;

    // Settle counter is 4 bits wide, so the window tops out at 15 cycles.
    localparam int SETTLE_CNT_W = 4;
    localparam int SETTLE_MAX   = 15;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO holding captured ALU results; head is presented combinationally.
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Zero when empty so the response data reads 0 out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked front end for the combinational KGP ALU: accept, settle, capture, return in order.
// Optional statistics counters are enabled with ALU_SEQ_STATS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int OP_W       = DEF_OP_W,
    parameter int RES_W      = DEF_RES_W,
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [A_W-1:0]   req_a,
    input  logic [B_W-1:0]   req_b,
    input  logic [OP_W-1:0]  req_op,
    output logic [A_W-1:0]   alu_a,
    output logic [B_W-1:0]   alu_b,
    output logic [OP_W-1:0]  alu_c,
    input  logic [RES_W-1:0] alu_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic             busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_stall
`endif
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LD = SETTLE_CNT_W'(SETTLE_CYC - 1);

    seq_state_e              state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                    accept, push;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    fifo_full, fifo_empty;

    // Only IDLE accepts, and nothing is in flight there, so free space is just !full.
    assign req_ready = (state_q == IDLE) && !fifo_full;
    assign rsp_valid = !fifo_empty;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    cnt_d   = SETTLE_LD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            CAPTURE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_c   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                alu_a <= req_a;
                alu_b <= req_b;
                alu_c <= req_op;
            end
        end
    end

    alu_seq_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rsp_ready),
        .din   (alu_d),
        .dout  (rsp_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (push && stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (req_valid && !req_ready && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a transaction-level reference model.
module tb_alu_op_sequencer;

    localparam int S     = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] req_a = '0, req_b = '0;
    logic [3:0] req_op = '0;
    logic [5:0] alu_a, alu_b;
    logic [3:0] alu_c;
    logic [7:0] alu_d;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_stall;
`endif

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(logic [5:0] a, logic [5:0] b, logic [3:0] op);
        if (op == 4'b1111) return {2'b0, a} ^ {2'b0, b};
        if (op == 4'b0000) return {2'b0, a} + {2'b0, b};
        return 8'hA5;
    endfunction

    assign alu_d = alu_fn(alu_a, alu_b, alu_c);

    alu_op_sequencer #(
        .SETTLE_CYC (S),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_d     (alu_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an op accepted at edge k lands in the queue at edge k+S+1.
    int         cyc = 0;
    bit         inflight = 0;
    int         done_at = 0;
    logic [7:0] pend_res = '0;
    logic [5:0] m_a = '0, m_b = '0;
    logic [3:0] m_c = '0;
    logic [7:0] mq[$];
    int         m_ops = 0, m_stall = 0;

    initial forever begin
        bit pred_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            inflight = 0; mq.delete();
            m_a = '0; m_b = '0; m_c = '0;
            m_ops = 0; m_stall = 0;
        end else begin
            pred_ready = !inflight && (mq.size() < DEPTH);
            if (req_valid && !pred_ready && m_stall < 16'hFFFF) m_stall++;
            if (mq.size() != 0 && rsp_ready) void'(mq.pop_front());
            if (inflight && cyc == done_at) begin
                mq.push_back(pend_res);
                inflight = 0;
                if (m_ops < 16'hFFFF) m_ops++;
            end
            if (req_valid && pred_ready) begin
                inflight = 1;
                done_at  = cyc + S + 1;
                m_a = req_a; m_b = req_b; m_c = req_op;
                pend_res = alu_fn(req_a, req_b, req_op);
            end
        end
    end

    // Per-cycle compare against the model, plus observation of pops/accepts/stalls.
    logic [7:0] got[$];
    int acc_seen = 0, stall_seen = 0;

    initial forever begin
        @(negedge clk);
        if (!rst && cyc > 0) begin
            chk("req_ready", req_ready, !inflight && mq.size() < DEPTH);
            chk("rsp_valid", rsp_valid, mq.size() != 0);
            chk("busy", busy, inflight || mq.size() != 0);
            if (mq.size() != 0) chk("rsp_data", rsp_data, mq[0]);
            chk("alu_abc", {alu_a, alu_b, alu_c}, {m_a, m_b, m_c});
`ifdef ALU_SEQ_STATS_EN
            chk("stat_ops", stat_ops, m_ops);
            chk("stat_stall", stat_stall, m_stall);
`endif
            if (rsp_valid && rsp_ready) got.push_back(rsp_data);
            if (req_valid && req_ready) acc_seen++;
            if (req_valid && !req_ready) stall_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge, i.e. in the first SETTLE cycle.
    task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [3:0] op);
        int t = 0;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        while (!req_ready && t < 300) begin tick(); t++; end
        if (!req_ready) begin
            chk("send_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 300) begin tick(); t++; end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bp [6];
        exp_bp = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};

        repeat (3) tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'd0);
        chk("rst_alu", {alu_a, alu_b, alu_c}, 16'd0);
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);

        // Single add: rsp_valid appears S+2 cycles counting the accept cycle as cycle 0.
        rsp_ready = 1'b1;
        send(6'b001000, 6'b000010, 4'b0000);
        chk("settle_alu_a", alu_a, 6'd8);
        repeat (S) tick();
        chk("lat_not_early", rsp_valid, 1'b0);
        chk("settle_alu_hold", {alu_a, alu_b, alu_c}, {6'd8, 6'd2, 4'd0});
        tick();
        chk("lat_valid", rsp_valid, 1'b1);
        chk("add_data", rsp_data, 8'd10);
        wait_idle("idle_after_add");

        send(6'd8, 6'd2, 4'b1111);
        repeat (S + 1) tick();
        chk("xor_data", rsp_data, 8'd10);
        wait_idle("idle_after_xor");

        send(6'd63, 6'd1, 4'b0000);
        repeat (S + 1) tick();
        chk("add_carry", rsp_data, 8'd64);
        send(6'd63, 6'd1, 4'b1111);
        repeat (S + 1) tick();
        chk("xor_ones", rsp_data, 8'd62);
        wait_idle("idle_after_carry");

        // One entry parked while the next op captures: push and pop on the same edge.
        rsp_ready = 1'b0;
        got.delete();
        send(6'd3, 6'd4, 4'b0000);
        repeat (S + 1) tick();
        chk("pp_first_valid", rsp_valid, 1'b1);
        send(6'd12, 6'd5, 4'b1111);
        repeat (S) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("pp_valid", rsp_valid, 1'b1);
        chk("pp_data", rsp_data, 8'd9);
        chk("pp_popped", got.size() == 1 ? got[0] : 8'hFF, 8'd7);
        rsp_ready = 1'b1;
        wait_idle("idle_after_pp");

        // Back-pressure with a clean slate so the statistics start at zero.
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b0;
        got.delete();
        acc_seen = 0; stall_seen = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(6'(i), 6'd1, 4'b0000);
            end
            begin
                repeat (30) tick();
                chk("bp_accepts", acc_seen, 4);
                chk("bp_ready_low", req_ready, 1'b0);
                chk("bp_busy", busy, 1'b1);
                rsp_ready = 1'b1;
            end
        join
        wait_idle("idle_after_bp");
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("bp_order", i < got.size() ? got[i] : 8'hFF, exp_bp[i]);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops_bp", stat_ops, 16'd6);
        chk("stat_stall_bp", stat_stall, stall_seen);
`endif

        // Reset during SETTLE aborts the op.
        send(6'd5, 6'd3, 4'b0000);
        rst = 1'b1;
        tick();
        chk("abort_valid", rsp_valid, 1'b0);
        chk("abort_alu", {alu_a, alu_b, alu_c}, 16'd0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        chk("abort_ready", req_ready, 1'b1);
        repeat (S + 3) tick();
        chk("abort_no_result", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
